proto_field_encoder: RTL

PROTO_FIELD_ENCODER -- requirements
Module: proto_field_encoder

---
 rtl/proto_wire_pkg.sv | 23 ++
 rtl/proto_varint_ser.sv | 46 ++++
 rtl/proto_field_encoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/proto_wire_pkg.sv
// Shared protobuf wire-format definitions: wire-type encoding, tag sizing and
// varint length limits used by the field encoder and its serializer.
package proto_wire_pkg;

   localparam int IDENTIFIER_SIZE  = 3;
   localparam int MAX_VARINT_BYTES = 10;

   typedef enum logic [IDENTIFIER_SIZE-1:0] {
      WT_VARINT = 3'd0,
      WT_I64    = 3'd1,
      WT_LEN    = 3'd2,
      WT_I32    = 3'd5
   } wire_type_e;

   function automatic int tag_width(input int field_num_w);
      return field_num_w + IDENTIFIER_SIZE;
   endfunction

   function automatic logic wt_supported(input logic [IDENTIFIER_SIZE-1:0] wt);
      return (wt == WT_VARINT) || (wt == WT_I64) || (wt == WT_LEN) || (wt == WT_I32);
   endfunction

endpackage

// File: rtl/proto_varint_ser.sv
// LEB128 serializer: holds the unsent remainder of a varint and presents the
// current 7-bit group with its continuation flag.
module proto_varint_ser
   import proto_wire_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [63:0] load_value,
   input  logic        advance,
   output logic [7:0]  byte_out,
   output logic        is_last
);

   logic [63:0] rem_q, rem_d;
   logic [3:0]  idx_q, idx_d;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rem_d = rem_q;
      idx_d = idx_q;
      if (load) begin
         rem_d = load_value;
         idx_d = 4'd0;
      end else if (advance) begin
         rem_d = rem_q >> 7;
         idx_d = idx_q + 4'd1;
      end
   end

   // The index cap bounds a 64-bit value to MAX_VARINT_BYTES groups.
   assign is_last  = (rem_q[63:7] == 57'd0) || (idx_q == 4'(MAX_VARINT_BYTES - 1));
   assign byte_out = {~is_last, rem_q[6:0]};

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         idx_q <= '0;
      end else begin
         rem_q <= rem_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/proto_field_encoder.sv
// Protobuf field encoder: accepts a field descriptor and streams its tag plus
// varint or little-endian fixed payload as a byte stream with valid/ready.
module proto_field_encoder
   import proto_wire_pkg::*;
#(
   parameter int FIELD_NUM_W = 4,
   parameter int VALUE_W     = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [FIELD_NUM_W-1:0] in_field_num,
   input  logic [2:0]             in_wire_type,
   input  logic [VALUE_W-1:0]     in_value,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_data,
   output logic                   out_last,
   output logic                   err_wire_type
);

   localparam int TAG_W = tag_width(FIELD_NUM_W);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_TAG    = 2'd1;
   localparam logic [1:0] ST_VARINT = 2'd2;
   localparam logic [1:0] ST_FIXED  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [2:0]         wire_type_q, wire_type_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic [3:0]         byte_cnt_q, byte_cnt_d;
   logic               err_q, err_d;

   logic               in_hs, out_fire;
   logic [TAG_W-1:0]   tag;
   logic               ser_load, ser_advance, ser_last;
   logic [63:0]        ser_load_value;
   logic [7:0]         ser_byte;
   logic [VALUE_W-1:0] fixed_shift;
   logic               fixed_last;
   logic               to_varint;

   assign in_hs       = in_valid && in_ready;
   assign out_fire    = out_valid && out_ready;
   assign tag         = {in_field_num, in_wire_type};
   assign fixed_shift = value_q >> {byte_cnt_q, 3'b000};
   assign fixed_last  = (byte_cnt_q == ((wire_type_q == WT_I32) ? 4'd3 : 4'd7));
   assign to_varint   = (wire_type_q == WT_VARINT) || (wire_type_q == WT_LEN);

   // One serializer carries the tag first, then is reloaded with the varint payload.
   assign ser_load       = (in_hs && wt_supported(in_wire_type))
                        || (state_q == ST_TAG && out_fire && ser_last && to_varint);
   assign ser_load_value = (state_q == ST_IDLE) ? {{(64-TAG_W){1'b0}}, tag} : value_q;
   assign ser_advance    = out_fire && (state_q == ST_TAG || state_q == ST_VARINT);

   proto_varint_ser u_ser (
      .clk        (clk),
      .rst        (rst),
      .load       (ser_load),
      .load_value (ser_load_value),
      .advance    (ser_advance),
      .byte_out   (ser_byte),
      .is_last    (ser_last)
   );

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q != ST_IDLE);
      out_data  = 8'h00;
      out_last  = 1'b0;
      case (state_q)
         ST_TAG:    out_data = ser_byte;
         ST_VARINT: begin
            out_data = ser_byte;
            out_last = ser_last;
         end
         ST_FIXED:  begin
            out_data = fixed_shift[7:0];
            out_last = fixed_last;
         end
         default: ;
      endcase
   end

   assign err_wire_type = err_q;

   always_comb begin
      state_d     = state_q;
      wire_type_d = wire_type_q;
      value_d     = value_q;
      byte_cnt_d  = byte_cnt_q;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_hs) begin
               wire_type_d = in_wire_type;
               value_d     = in_value;
               byte_cnt_d  = 4'd0;
               if (wt_supported(in_wire_type)) state_d = ST_TAG;
               else                            err_d   = 1'b1;
            end
         end
         ST_TAG: begin
            if (out_fire && ser_last) state_d = to_varint ? ST_VARINT : ST_FIXED;
         end
         ST_VARINT: begin
            if (out_fire && ser_last) state_d = ST_IDLE;
         end
         ST_FIXED: begin
            if (out_fire) begin
               if (fixed_last) begin
                  state_d    = ST_IDLE;
                  byte_cnt_d = 4'd0;
               end else begin
                  byte_cnt_d = byte_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wire_type_q <= '0;
         value_q     <= '0;
         byte_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wire_type_q <= wire_type_d;
         value_q     <= value_d;
         byte_cnt_q  <= byte_cnt_d;
         err_q       <= err_d;
      end
   end

endmodule
